// File: rtl/sirv_gnrl_crd_tx_pkg.sv
// Shared general helpers for the credit link: the credit counter width and the legal credit bound.
package sirv_gnrl_crd_tx_pkg;

  localparam int CRD_MAX = 15;

  // Bits needed to hold the values 0..crd inclusive.
  function automatic int crd_width(input int crd);
    return $clog2(crd + 1);
  endfunction

endpackage

// File: rtl/sirv_gnrl_crd_cnt.sv
// Saturating credit up/down counter, resets full; latency 1 cycle from inc/dec to cnt.
// No backpressure: a return into a full count saturates and latches the sticky ovf flag.
module sirv_gnrl_crd_cnt
  import sirv_gnrl_crd_tx_pkg::*;
#(
  parameter  int CRD = 4,
  localparam int CW  = crd_width(CRD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          ovf
);

  logic          full;
  logic          empty;
  logic          cnt_en;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_set;

  assign full    = (cnt == CW'(CRD));
  assign empty   = (cnt == '0);
  // Only a lone return against a full count is an error; inc together with dec is a legal swap.
  assign ovf_set = inc & ~dec & full;

  always_comb begin
    cnt_en  = 1'b0;
    cnt_nxt = cnt;
    if (inc && !dec && !full) begin
      cnt_en  = 1'b1;
      cnt_nxt = cnt + CW'(1);
    end else if (dec && !inc && !empty) begin
      cnt_en  = 1'b1;
      cnt_nxt = cnt - CW'(1);
    end
  end

  sirv_gnrl_dfflr #(.DW(CW), .RST_VAL(CW'(CRD))) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (cnt_en),
    .dnxt  (cnt_nxt),
    .qout  (cnt)
  );

  sirv_gnrl_dfflr #(.DW(1), .RST_VAL(1'b0)) u_ovf (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (ovf_set),
    .dnxt  (1'b1),
    .qout  (ovf)
  );

endmodule

// File: rtl/sirv_gnrl_dffs.sv
// General flop cells: dfflr is a load-enable flop with async active-low reset to RST_VAL.
// dffl is a plain load-enable flop with no reset, used for data paths.
module sirv_gnrl_dfflr #(
  parameter int            DW      = 1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= RST_VAL;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

module sirv_gnrl_dffl #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/sirv_gnrl_crd_tx.sv
// Credit-based transmitter: forwards accepted beats as one-cycle o_vld strobes, latency 1 cycle.
// Backpressure: i_rdy drops while no credits remain; credits come back one per crd_rtn pulse.
module sirv_gnrl_crd_tx
  import sirv_gnrl_crd_tx_pkg::*;
#(
  parameter  int DW  = 32,
  parameter  int CRD = 4,
  localparam int CW  = crd_width(CRD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  output logic [DW-1:0] o_dat,
  input  logic          crd_rtn,
  output logic [CW-1:0] crd_cnt,
  output logic          crd_ovf,
  output logic          idle
);

  logic acc;

  // Ready comes from the count register alone so upstream sees no combinational loop.
  assign i_rdy = (crd_cnt != '0);
  assign acc   = i_vld & i_rdy;
  assign idle  = (crd_cnt == CW'(CRD)) & ~o_vld;

  sirv_gnrl_crd_cnt #(.CRD(CRD)) u_crd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (crd_rtn),
    .dec   (acc),
    .cnt   (crd_cnt),
    .ovf   (crd_ovf)
  );

  sirv_gnrl_dfflr #(.DW(1), .RST_VAL(1'b0)) u_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .lden  (1'b1),
    .dnxt  (acc),
    .qout  (o_vld)
  );

  sirv_gnrl_dffl #(.DW(DW)) u_dat (
    .clk   (clk),
    .lden  (acc),
    .dnxt  (i_dat),
    .qout  (o_dat)
  );

endmodule
